// File: rtl/uart_rx_axis.sv
// uart_rx_axis: parametrised UART receiver with an AXI4-Stream master output.
//
// Deserialises an asynchronous, idle-high RxD line (DATA_BITS data bits sent
// LSB first, optional odd/even parity, 1 or 2 stop bits). Each completed
// frame becomes one word in a single-entry output register.
//
// Handshake: a beat transfers on a rising i_clk edge where
// o_m_axis_tvalid & i_m_axis_tready. While tvalid is high and tready is low,
// tdata/tuser hold still. The receiver never waits on tready: a frame that
// completes while the register is full and not being drained is dropped, and
// the next word that does load carries overrun = 1.
//
// Ports:
//   i_clk            system clock (rising edge)
//   i_rst_n          asynchronous active-low reset; aborts any frame in flight
//   i_rxd            asynchronous serial input, idle high
//   o_m_axis_tvalid  word available
//   i_m_axis_tready  consumer accepts word
//   o_m_axis_tdata   received data word
//   o_m_axis_tuser   {overrun, parity_err, framing_err} of this word
//   o_busy           FSM outside IDLE
//   o_break          line held low through a whole frame, until it goes high
//   o_dbg_state      current FSM state encoding, for observation only
module uart_rx_axis #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rxd,
    output logic                 o_m_axis_tvalid,
    input  logic                 i_m_axis_tready,
    output logic [DATA_BITS-1:0] o_m_axis_tdata,
    output logic [2:0]           o_m_axis_tuser,
    output logic                 o_busy,
    output logic                 o_break,
    output logic [2:0]           o_dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;

    // Strobes from the FSM to the datapath.
    logic start_ok, sample_data, sample_par, sample_stop, frame_end;

    logic [DATA_BITS-1:0] shift_q;
    logic                 all_zero_q, parity_err_q, framing_q;
    logic                 done_q, done_pe_q, done_fe_q;
    logic [DATA_BITS-1:0] done_data_q;
    logic                 overrun_q;

    assign rxs         = sync_q[SYNC_STAGES-1];
    assign o_busy      = (state_q != S_IDLE);
    assign o_dbg_state = state_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q    <= '1;
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_rxd};
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // clk_cnt counts cycles since entering a bit; a sample is taken when it
    // reaches the end of the interval, then it restarts for the next bit.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        start_ok    = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!rxs) begin
                    state_d   = S_START;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (clk_cnt_q == CNT_W'(HALF - 1)) begin
                    clk_cnt_d = '0;
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                        start_ok = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d   = '0;
                    sample_data = 1'b1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d  = '0;
                    sample_par = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d   = '0;
                    sample_stop = 1'b1;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        frame_end = 1'b1;
                        state_d   = (all_zero_q && !rxs) ? S_BREAK : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                clk_cnt_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame datapath. The finished word is staged in done_* so the output
    // register loads exactly one cycle after the final stop sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q      <= '0;
            all_zero_q   <= 1'b0;
            parity_err_q <= 1'b0;
            framing_q    <= 1'b0;
            done_q       <= 1'b0;
            done_data_q  <= '0;
            done_pe_q    <= 1'b0;
            done_fe_q    <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_ok) begin
                all_zero_q   <= 1'b1;
                parity_err_q <= 1'b0;
                framing_q    <= 1'b0;
            end
            if (sample_data) begin
                shift_q    <= {rxs, shift_q[DATA_BITS-1:1]};
                all_zero_q <= all_zero_q & ~rxs;
            end
            if (sample_par) begin
                parity_err_q <= ((^shift_q) ^ rxs) != (PARITY == 1);
                all_zero_q   <= all_zero_q & ~rxs;
            end
            if (sample_stop) begin
                framing_q  <= framing_q | ~rxs;
                all_zero_q <= all_zero_q & ~rxs;
            end
            if (frame_end) begin
                done_q      <= 1'b1;
                done_data_q <= shift_q;
                done_pe_q   <= parity_err_q;
                done_fe_q   <= framing_q | ~rxs;
                if (all_zero_q && !rxs) o_break <= 1'b1;
            end
            if (state_q == S_BREAK && rxs) o_break <= 1'b0;
        end
    end

    // Single-entry AXIS output register with overrun tracking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_m_axis_tvalid <= 1'b0;
            o_m_axis_tdata  <= '0;
            o_m_axis_tuser  <= '0;
            overrun_q       <= 1'b0;
        end else begin
            if (o_m_axis_tvalid && i_m_axis_tready) o_m_axis_tvalid <= 1'b0;
            if (done_q) begin
                if (!o_m_axis_tvalid || i_m_axis_tready) begin
                    o_m_axis_tvalid <= 1'b1;
                    o_m_axis_tdata  <= done_data_q;
                    o_m_axis_tuser  <= {overrun_q, done_pe_q, done_fe_q};
                    overrun_q       <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis: three instances (8N1 @87, 8E1 @16, 7O2 @16), each
// fed whole serial frames; a frame-level model predicts the word, its flags
// and overrun from the frame contents and the consumer's tready level.
module tb_uart_rx_axis;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic       rst_ab, rst_c;
    logic [2:0] rxd, rdy;

    logic       tvalid_a, busy_a, brk_a;
    logic [7:0] tdata_a;
    logic [2:0] tuser_a, dbg_a;
    logic       tvalid_b, busy_b, brk_b;
    logic [7:0] tdata_b;
    logic [2:0] tuser_b, dbg_b;
    logic       tvalid_c, busy_c, brk_c;
    logic [6:0] tdata_c;
    logic [2:0] tuser_c, dbg_c;

    uart_rx_axis dut_a (
        .i_clk(clk), .i_rst_n(rst_ab), .i_rxd(rxd[0]),
        .o_m_axis_tvalid(tvalid_a), .i_m_axis_tready(rdy[0]),
        .o_m_axis_tdata(tdata_a), .o_m_axis_tuser(tuser_a),
        .o_busy(busy_a), .o_break(brk_a), .o_dbg_state(dbg_a)
    );

    uart_rx_axis #(.CLKS_PER_BIT(16), .PARITY(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_ab), .i_rxd(rxd[1]),
        .o_m_axis_tvalid(tvalid_b), .i_m_axis_tready(rdy[1]),
        .o_m_axis_tdata(tdata_b), .o_m_axis_tuser(tuser_b),
        .o_busy(busy_b), .o_break(brk_b), .o_dbg_state(dbg_b)
    );

    uart_rx_axis #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
        .i_clk(clk), .i_rst_n(rst_c), .i_rxd(rxd[2]),
        .o_m_axis_tvalid(tvalid_c), .i_m_axis_tready(rdy[2]),
        .o_m_axis_tdata(tdata_c), .o_m_axis_tuser(tuser_c),
        .o_busy(busy_c), .o_break(brk_c), .o_dbg_state(dbg_c)
    );

    int cpb[3]   = '{87, 16, 16};
    int dbits[3] = '{8, 8, 7};
    int par[3]   = '{0, 2, 1};
    int stops[3] = '{1, 1, 2};

    int total = 0;
    int bad   = 0;

    // Expected beats per instance: {tuser, 9-bit zero-extended tdata}.
    logic [11:0] exp_q0[$], exp_q1[$], exp_q2[$];
    bit ovr[3];
    bit full[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void qpush(int u, logic [11:0] w);
        case (u)
            0: exp_q0.push_back(w);
            1: exp_q1.push_back(w);
            default: exp_q2.push_back(w);
        endcase
    endfunction

    function automatic int qsize(int u);
        case (u)
            0: return exp_q0.size();
            1: return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [11:0] qfront(int u);
        case (u)
            0: return exp_q0[0];
            1: return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    function automatic void qpop(int u);
        case (u)
            0: void'(exp_q0.pop_front());
            1: void'(exp_q1.pop_front());
            default: void'(exp_q2.pop_front());
        endcase
    endfunction

    // Frame-level model: a word loads if the register is free, otherwise it
    // is lost and the next loaded word reports overrun.
    task automatic model_frame(int u, logic [8:0] d, bit bp, bit bs);
        logic [2:0] user;
        user = {ovr[u], (par[u] != 0) && bp, bs};
        if (!full[u]) begin
            qpush(u, {user, d});
            ovr[u]  = 1'b0;
            full[u] = !rdy[u];
        end else begin
            ovr[u] = 1'b1;
        end
    endtask

    task automatic drive_bits(int u, logic [15:0] bits, int n);
        for (int i = 0; i < n; i++) begin
            rxd[u] = bits[i];
            repeat (cpb[u]) @(negedge clk);
        end
    endtask

    // bp inverts the parity bit, bs forces every stop bit low.
    task automatic send(int u, logic [8:0] din, bit bp, bit bs);
        logic [15:0] bits;
        logic [8:0]  d;
        logic        p;
        int          n;
        d = din & 9'((1 << dbits[u]) - 1);
        p = ^d;
        if (par[u] == 1) p = ~p;
        p = p ^ bp;
        bits = '0;
        n = 1;
        for (int i = 0; i < dbits[u]; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (par[u] != 0) begin
            bits[n] = p;
            n++;
        end
        for (int i = 0; i < stops[u]; i++) begin
            bits[n] = !bs;
            n++;
        end
        model_frame(u, d, bp, bs);
        @(negedge clk);
        drive_bits(u, bits, n);
        rxd[u] = 1'b1;
        repeat (cpb[u] * $urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic set_ready(int u, bit v);
        @(posedge clk);
        #1 rdy[u] = v;
        if (v) full[u] = 1'b0;
    endtask

    task automatic send_random(int u, int count);
        for (int i = 0; i < count; i++)
            send(u, 9'($urandom_range(0, 511)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0);
    endtask

    logic [11:0] beat[3];
    logic [2:0]  vld;
    assign beat[0] = {tuser_a, 1'b0, tdata_a};
    assign beat[1] = {tuser_b, 1'b0, tdata_b};
    assign beat[2] = {tuser_c, 2'b00, tdata_c};
    assign vld     = {tvalid_c, tvalid_b, tvalid_a};

    // Every valid cycle is compared with the head of the expected queue, so
    // a held word that changes under backpressure is caught too.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (vld[u]) begin
                if (qsize(u) == 0) begin
                    check($sformatf("extra_beat_u%0d", u), 32'(vld[u]), 32'd0);
                end else begin
                    check($sformatf("beat_u%0d", u), 32'(beat[u]), 32'(qfront(u)));
                    if (rdy[u]) qpop(u);
                end
            end
        end
    end

    initial begin
        rst_ab = 1'b0;
        rst_c  = 1'b0;
        rxd    = '1;
        rdy    = '1;
        repeat (3) @(negedge clk);
        check("rst_tvalid", {tvalid_c, tvalid_b, tvalid_a}, 0);
        check("rst_tdata_a", tdata_a, 0);
        check("rst_tuser_a", tuser_a, 0);
        check("rst_busy", {busy_c, busy_b, busy_a}, 0);
        check("rst_break", {brk_c, brk_b, brk_a}, 0);
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 at 87 clocks/bit.
        send(0, 9'h55, 0, 0);
        send(0, 9'h3C, 0, 1);
        send(0, 9'h3C, 0, 0);

        // Backpressure: 0x11 held, 0x22/0x33 lost, 0x44 flags overrun.
        set_ready(0, 1'b0);
        send(0, 9'h11, 0, 0);
        send(0, 9'h22, 0, 0);
        send(0, 9'h33, 0, 0);
        set_ready(0, 1'b1);
        send(0, 9'h44, 0, 0);

        // Short glitch: no word, FSM falls back to idle.
        @(negedge clk);
        rxd[0] = 1'b0;
        repeat (20) @(negedge clk);
        rxd[0] = 1'b1;
        check("glitch_busy_hi", busy_a, 1);
        for (int i = 0; i < 44; i++) begin
            if (!busy_a) break;
            @(negedge clk);
        end
        check("glitch_busy", busy_a, 0);
        repeat (cpb[0]) @(negedge clk);

        // Line low for two frame times: break word, then o_break until high.
        model_frame(0, 9'h000, 0, 1);
        rxd[0] = 1'b0;
        repeat (20 * cpb[0]) @(negedge clk);
        check("break_on", brk_a, 1);
        check("break_busy", busy_a, 1);
        rxd[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("break_off", brk_a, 0);
        check("break_idle", busy_a, 0);
        repeat (cpb[0]) @(negedge clk);
        send_random(0, 6);

        // 8E1: correct then inverted parity bit.
        send(1, 9'h0A3, 0, 0);
        send(1, 9'h0A3, 1, 0);
        send_random(1, 24);

        // 7O2, then reset in the middle of a second word's data bits.
        send(2, 9'h05A, 0, 0);
        @(negedge clk);
        drive_bits(2, 16'h000A, 4);
        rst_c  = 1'b0;
        rxd[2] = 1'b1;
        #1;
        check("midreset_tvalid", tvalid_c, 0);
        check("midreset_busy", busy_c, 0);
        @(negedge clk);
        rst_c   = 1'b1;
        ovr[2]  = 1'b0;
        full[2] = 1'b0;
        repeat (24 * cpb[2]) @(negedge clk);
        check("midreset_quiet", busy_c, 0);
        send_random(2, 20);

        repeat (200) @(negedge clk);
        check("drain_a", qsize(0), 0);
        check("drain_b", qsize(1), 0);
        check("drain_c", qsize(2), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis.md
Name: uart_rx_axis

Overview:
Parametrised successor to the fixed 8N1 UART receiver. It deserialises an asynchronous RxD line with configurable data width, parity and stop-bit count. It presents each received word on an AXI4-Stream master with full tvalid/tready backpressure, and per-word error flags carried on tuser. It is used in place of the basic receiver wherever the downstream consumer can stall, or where line errors must be reported.

Parameters:
CLKS_PER_BIT, 87, i_clk cycles per serial bit (>= 8); 10 MHz / 115200.
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
SYNC_STAGES, 2, flip-flops in the i_rxd synchroniser (>= 2).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rxd  in  1  asynchronous serial input, idle high
o_m_axis_tvalid  out  1  word available
i_m_axis_tready  in  1  consumer accepts word
o_m_axis_tdata  out  DATA_BITS  received data word
o_m_axis_tuser  out  3  {overrun, parity_err, framing_err} for this word
o_busy  out  1  high while the FSM is outside IDLE
o_break  out  1  break condition on the line (held low beyond one frame)

Behaviour:
- Reset is asynchronous and active-low on i_rst_n; all logic is clocked on i_clk rising edge.
- Reset values: synchroniser chain all 1s, FSM = IDLE, counters 0, o_m_axis_tvalid 0, tdata 0, tuser 0, o_busy 0, o_break 0, overrun-pending 0.
- Reset asserted mid-frame aborts the frame immediately. No partial word is ever emitted.
- i_rxd passes through SYNC_STAGES flip-flops. All decisions below use the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rxs == 0 -> START, with bit counter cleared.
- START: wait until cycle CLKS_PER_BIT/2 (integer divide) after entry, then sample rxs.
  - rxs == 1 -> false start; return to IDLE with no output.
  - rxs == 0 -> DATA.
- DATA: sample once every CLKS_PER_BIT cycles. Sample k goes to shift bit k, LSB first. After DATA_BITS samples: go to PARITY if PARITY != 0, else STOP.
- PARITY: one sample. parity_err = (XOR of data bits ^ sample) != (PARITY == 1).
- STOP: STOP_BITS samples, each CLKS_PER_BIT apart. Any stop sample == 0 sets framing_err.
- Frame completion happens on the cycle of the final stop sample.
  - If every data, parity and stop sample was 0: set o_break = 1, go to BREAK.
  - Otherwise go to IDLE.
- BREAK: remain until rxs == 1, then o_break = 0 and go to IDLE.
- Output register: single entry, AXIS-compliant.
  - tdata/tuser are stable while tvalid = 1 and tready = 0.
  - Transfer occurs when tvalid & tready on a rising edge.
- On frame completion, the word loads on the next edge (latency 1 cycle after the final stop sample) if either:
  - tvalid == 0, or
  - tvalid & tready on that same cycle (accept and load in one cycle, tvalid stays 1).
- tuser[2] of the loaded word = overrun-pending; overrun-pending is then cleared.
- Completion while the register is full and not accepted: the new word is dropped, the held word is unchanged, and overrun-pending is set. It is reported on the next loaded word.
- A break frame is delivered as a normal word: tdata = 0, framing_err = 1.
- o_busy = 1 in START, DATA, PARITY, STOP and BREAK.
- The FSM never waits on tready. The receiver keeps sampling regardless of backpressure.

Test Plan:
- Defaults, 0x55 driven as 8N1 at 8681 ns/bit, tready = 1 -> exactly one beat: tdata = 0x55, tuser = 3'b000, tvalid high 1 cycle.
- PARITY = 2, byte 0xA3 with correct even parity bit (0), then 0xA3 with parity bit 1 -> tuser = 000, then tuser = 3'b010; tdata = 0xA3 both times.
- Stop bit forced to 0 on byte 0x3C -> tdata = 0x3C, tuser = 3'b001. Then a valid 0x3C -> tuser = 000.
- tready = 0; send 0x11, 0x22, 0x33; then tready = 1 -> first beat 0x11/tuser 000 held stable throughout; 0x22 and 0x33 are lost. Next sent byte 0x44 -> tuser = 3'b100.
- Glitch: RxD low for 20 clocks (< CLKS_PER_BIT/2) -> no beat, o_busy returns to 0 within 44 cycles. Line held low 2 frame times -> beat tdata = 0x00 tuser = 001, o_break = 1 until line high.
- DATA_BITS = 7, STOP_BITS = 2, PARITY = 1, word 0x5A; then i_rst_n pulsed low mid-DATA of a second word -> first beat 0x5A/000. After reset: tvalid = 0, o_busy = 0 immediately, no beat from the aborted frame.
